// File: rtl/sort_result_streamer_if.sv
`default_nettype none
// ============================================================================
// Module   : sort_result_streamer_if
// Brief    : Memory read port plus valid/ready output stream of the unloader.
// Revision : 1.0
// ============================================================================
interface sort_result_streamer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output mem_rd_en,
    output mem_rd_addr,
    input  mem_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  mem_rd_en,
    input  mem_rd_addr,
    output mem_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface
`default_nettype wire

// File: rtl/sort_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : sort_result_streamer
// Brief    : Drains the sorted word memory onto a valid/ready stream, index 0 first.
// Revision : 1.0
// ============================================================================
module sort_result_streamer #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 10,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,          // active-low, asynchronous
  input  logic                   sort_done,
  sort_result_streamer_if.master bus,
  output logic                   busy,
  output logic                   stream_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              r_sort_done_q;
  logic [ADDR_W-1:0] r_addr;
  logic              r_all_issued;
  logic              r_in_flight;
  logic              r_in_flight_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic              r_fifo_last [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_trigger;
  logic              w_pop;
  logic              w_rd_en;
  logic [2:0]        w_occupancy;

  assign w_trigger   = sort_done & ~r_sort_done_q;
  assign bus.out_valid = (r_count != 2'd0);
  assign bus.out_data  = r_fifo_data[r_rd_ptr];
  assign bus.out_last  = r_fifo_last[r_rd_ptr];
  assign w_pop       = bus.out_valid & bus.out_ready;
  // Slots already committed: buffered words plus the read returning next edge.
  assign w_occupancy = {1'b0, r_count} + {2'b00, r_in_flight} - {2'b00, w_pop};

  assign bus.mem_rd_en   = w_rd_en;
  assign bus.mem_rd_addr = r_addr;
  assign busy            = (state == ST_STREAM);
  assign stream_done     = (state == ST_DONE);

  always_comb begin
    next_state = state;
    w_rd_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (w_trigger) next_state = ST_STREAM;
      end
      ST_STREAM: begin
        w_rd_en = ~r_all_issued & (w_occupancy < 3'd2);
        if (w_pop && bus.out_last) next_state = ST_DONE;
      end
      ST_DONE: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      r_sort_done_q <= 1'b0;
    end else begin
      state         <= next_state;
      r_sort_done_q <= sort_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr           <= '0;
      r_all_issued     <= 1'b0;
      r_in_flight      <= 1'b0;
      r_in_flight_last <= 1'b0;
    end else begin
      r_in_flight      <= w_rd_en;
      r_in_flight_last <= w_rd_en & (r_addr == LAST_ADDR);
      if (state != ST_STREAM) begin
        r_addr       <= '0;
        r_all_issued <= 1'b0;
      end else if (w_rd_en) begin
        // Hold at the final address rather than wrapping.
        if (r_addr == LAST_ADDR) r_all_issued <= 1'b1;
        else                     r_addr       <= r_addr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last[0] <= 1'b0;
      r_fifo_last[1] <= 1'b0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
      r_count        <= 2'd0;
    end else begin
      if (r_in_flight) begin
        r_fifo_data[r_wr_ptr] <= bus.mem_rd_data;
        r_fifo_last[r_wr_ptr] <= r_in_flight_last;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({r_in_flight, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_result_streamer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_result_streamer
// Brief    : Randomized self-checking bench; scoreboard expects mem[0..DEPTH-1] in order.
// Revision : 1.0
// ============================================================================
module tb_sort_result_streamer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 10;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sort_done  = 1'b0;
  logic sort_done1 = 1'b0;
  logic busy, stream_done, busy1, stream_done1;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] mem [DEPTH];

  sort_result_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  sort_result_streamer_if #(.DATA_W(DATA_W), .ADDR_W(1))      bus1 ();

  sort_result_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .sort_done(sort_done), .bus(bus),
    .busy(busy), .stream_done(stream_done)
  );

  sort_result_streamer #(.DATA_W(DATA_W), .DEPTH(1), .ADDR_W(1)) dut1 (
    .clk(clk), .rst(rst), .sort_done(sort_done1), .bus(bus1),
    .busy(busy1), .stream_done(stream_done1)
  );

  always #5 clk = ~clk;

  // Synchronous-read memories: data valid the cycle after the strobe
  always @(posedge clk) begin
    if (bus.mem_rd_en && int'(bus.mem_rd_addr) < DEPTH) bus.mem_rd_data <= mem[bus.mem_rd_addr];
    if (bus1.mem_rd_en) bus1.mem_rd_data <= (bus1.mem_rd_addr == 1'b0) ? 16'hBEEF : 16'h0000;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: ready=1, 1: alternating, 2: random, 3: ready=0 for 21 cycles then 1.
  // Caller arranges for the trigger to be sampled on the next rising edge.
  task automatic drain(input int mode, input int abort_after);
    int   idx = 0, next_addr = 0, issued = 0, cyc = 0;
    int   first_beat = -1, last_beat = -1;
    logic prev_stall = 1'b0, prev_last = 1'b0, xfer;
    logic [DATA_W-1:0] prev_data = '0;
    bit   done_seen = 1'b0;
    while (!done_seen && cyc < 400) begin
      @(negedge clk);
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (cyc % 2 == 0);
        2:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = (cyc >= 21);
      endcase
      #1;
      if (cyc == 0) begin
        check("lat_rd_en", bus.mem_rd_en, 1);
        check("lat_addr0", bus.mem_rd_addr, 0);
        check("lat_busy", busy, 1);
      end
      if (cyc == 1) check("lat_valid_lo", bus.out_valid, 0);
      if (cyc == 2) check("lat_valid_hi", bus.out_valid, 1);
      if (prev_stall) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, prev_data);
        check("hold_last", bus.out_last, prev_last);
      end
      if (bus.mem_rd_en) begin
        check("rd_addr", bus.mem_rd_addr, next_addr);
        check("rd_in_range", next_addr < DEPTH, 1);
        next_addr++;
        issued++;
      end
      xfer = bus.out_valid & bus.out_ready;
      if (xfer) begin
        check("beat_data", bus.out_data, (idx < DEPTH) ? mem[idx] : 16'hxxxx);
        check("beat_last", bus.out_last, idx == DEPTH - 1);
        if (first_beat < 0) first_beat = cyc;
        last_beat = cyc;
        idx++;
      end
      check("fifo_bound", (issued - idx) <= 2, 1);
      if (mode == 3 && cyc == 19) begin
        check("stall_reads", issued, 2);
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, mem[0]);
      end
      if (stream_done) begin
        check("done_count", idx, DEPTH);
        check("done_busy", busy, 0);
        done_seen = 1'b1;
      end
      if (abort_after >= 0 && idx == abort_after) return;
      prev_stall = bus.out_valid & ~bus.out_ready;
      prev_data  = bus.out_data;
      prev_last  = bus.out_last;
      cyc++;
    end
    check("done_seen", done_seen, 1);
    check("beat_count", idx, DEPTH);
    if (mode == 0 || mode == 3) check("back_to_back", last_beat - first_beat, DEPTH - 1);
    @(negedge clk);
    #1;
    check("done_pulse_1cyc", stream_done, 0);
    check("idle_rd_en", bus.mem_rd_en, 0);
  endtask

  task automatic retrigger();
    @(negedge clk);
    sort_done = 1'b0;
    @(negedge clk);
    sort_done = 1'b1;
  endtask

  initial begin
    int beats1;
    bit done1;
    static logic [DATA_W-1:0] t1_data [DEPTH] = '{1, 2, 5, 23, 31, 44, 55, 70, 88, 99};
    bus.out_ready  = 1'b0;
    bus1.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = t1_data[i];

    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", stream_done, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_busy", busy, 0);

    // T1: full-rate drain
    sort_done = 1'b1;
    drain(0, -1);

    // T4: level held high must not start another drain
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("no_retrig_busy", busy, 0);
      check("no_retrig_rd", bus.mem_rd_en, 0);
    end
    retrigger();
    drain(0, -1);

    // T2: alternating then random backpressure
    retrigger();
    drain(1, -1);
    retrigger();
    drain(2, -1);

    // T3: long stall right after trigger
    retrigger();
    drain(3, -1);

    // T5: async reset mid-stream, sort_done still high at release retriggers
    retrigger();
    drain(0, 5);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_data", bus.out_data, 0);
    check("arst_last", bus.out_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", stream_done, 0);
    check("arst_rd_en", bus.mem_rd_en, 0);
    repeat (3) begin
      @(negedge clk);
      check("arst_no_rd", bus.mem_rd_en, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    drain(0, -1);

    // Randomized contents and backpressure
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
      retrigger();
      drain(2, -1);
    end

    // T6: single-word array
    @(negedge clk);
    sort_done1     = 1'b1;
    bus1.out_ready = 1'b1;
    beats1 = 0;
    done1  = 1'b0;
    for (int c = 0; c < 12 && !done1; c++) begin
      @(negedge clk);
      #1;
      if (bus1.out_valid && bus1.out_ready) begin
        check("d1_data", bus1.out_data, 16'hBEEF);
        check("d1_last", bus1.out_last, 1);
        beats1++;
      end
      if (stream_done1) begin
        check("d1_busy_at_done", busy1, 0);
        done1 = 1'b1;
      end
    end
    check("d1_beats", beats1, 1);
    check("d1_done_seen", done1, 1);
    @(negedge clk);
    #1;
    check("d1_done_pulse", stream_done1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
